// File: rtl/sram_rd_streamer.sv
// Sweeps a contiguous address range of a synchronous storage bank and streams
// each word out over valid/ready, using a 2-entry buffer and read credits.
module sram_rd_streamer #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   len,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic              inflight_q, inflight_d;
   logic [1:0]        count_q, count_d;
   logic              wr_idx_q, wr_idx_d;
   logic              rd_idx_q, rd_idx_d;
   logic [DATA_W-1:0] buf_q [2];
   logic [DATA_W-1:0] buf_d [2];

   logic              push;
   logic              pop;
   logic              issue;
   logic [1:0]        credit_used;

   // Credits count the slot freed by a same-cycle pop, which is what lets a
   // continuously-ready consumer receive one word per cycle.
   always_comb begin
      push        = inflight_q;
      pop         = (count_q != 2'd0) && out_ready;
      credit_used = count_q + {1'b0, inflight_q} - {1'b0, pop};
      issue       = (state_q == READ) && (rem_q != '0) && (credit_used < 2'd2);
   end

   always_comb begin
      count_d    = count_q + {1'b0, push} - {1'b0, pop};
      wr_idx_d   = wr_idx_q ^ push;
      rd_idx_d   = rd_idx_q ^ pop;
      inflight_d = issue;
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      assign buf_d[gi] = (push && (wr_idx_q == 1'(gi))) ? mem_rdata : buf_q[gi];

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            buf_q[gi] <= '0;
         end else begin
            buf_q[gi] <= buf_d[gi];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (len != '0) begin
                  ptr_d   = base_addr;
                  rem_d   = len;
                  state_d = READ;
               end else begin
                  state_d = FIN;
               end
            end
         end
         READ: begin
            if (issue) begin
               ptr_d = ptr_q + ADDR_W'(1);
               rem_d = rem_q - (ADDR_W+1)'(1);
               if (rem_q == (ADDR_W+1)'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Finish as soon as the final word leaves, so done follows it by one cycle.
            if ((count_d == 2'd0) && !inflight_d) begin
               state_d = FIN;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         rem_q      <= '0;
         inflight_q <= 1'b0;
         count_q    <= 2'd0;
         wr_idx_q   <= 1'b0;
         rd_idx_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         rem_q      <= rem_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         wr_idx_q   <= wr_idx_d;
         rd_idx_q   <= rd_idx_d;
      end
   end

   assign mem_rd_en = issue;
   assign mem_addr  = issue ? ptr_q : '0;
   assign out_valid = (count_q != 2'd0);
   assign out_data  = buf_q[rd_idx_q];
   assign busy      = (state_q == READ) || (state_q == DRAIN);
   assign done      = (state_q == FIN);

endmodule
